// File: rtl/hypot_req_arbiter.sv
// hypot_req_arbiter: round-robin share of one multi-cycle hypotenuse engine among NREQ requesters
// req_valid/req_x/req_y -> req_ready accept pulse; eng_start/eng_x/eng_y -> engine, eng_done/eng_result <- engine;
// rsp_valid/rsp_data/rsp_err per-requester response pulse; busy = not idle; grant_id = current or last grant.
module hypot_req_arbiter #(
  parameter int NREQ = 4,
  parameter int W = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*W-1:0]       req_x,
  input  logic [NREQ*W-1:0]       req_y,
  output logic [NREQ-1:0]         req_ready,
  output logic                    eng_start,
  output logic [W-1:0]            eng_x,
  output logic [W-1:0]            eng_y,
  input  logic                    eng_done,
  input  logic [W-1:0]            eng_result,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [W-1:0]            rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);
  localparam int GW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [GW-1:0] last_grant, pick, idx;
  logic [TW-1:0] timer;
  logic found, timeout;
  assign timeout = timer == TW'(TIMEOUT - 1);
  // descending scan so the nearest index after last_grant is the one left in pick
  always_comb begin
    pick = last_grant;
    idx = last_grant;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = GW'((int'(last_grant) + k) % NREQ);
      if (req_valid[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = found ? ISSUE : IDLE;
      ISSUE: state_n = WAIT;
      WAIT:  state_n = (eng_done || timeout) ? RESP : WAIT;
      RESP:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready <= '0;
      eng_start <= 1'b0;
      eng_x <= '0;
      eng_y <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      busy <= 1'b0;
      grant_id <= '0;
      timer <= '0;
      last_grant <= GW'(NREQ - 1);
    end else begin
      req_ready <= '0;
      eng_start <= 1'b0;
      rsp_valid <= '0;
      busy <= state_n != IDLE;
      timer <= state == WAIT ? timer + TW'(1) : '0;
      if (state == IDLE && found) begin
        grant_id <= pick;
        eng_x <= req_x[pick*W +: W];
        eng_y <= req_y[pick*W +: W];
        req_ready <= NREQ'(1) << pick;
        eng_start <= 1'b1;
      end
      // done beats timeout when both land in the same cycle
      if (state == WAIT && (eng_done || timeout)) begin
        rsp_data <= eng_done ? eng_result : '0;
        rsp_err <= !eng_done;
        rsp_valid <= NREQ'(1) << grant_id;
      end
      if (state == RESP) last_grant <= grant_id;
    end
  end
endmodule

// File: tb/tb_hypot_req_arbiter.sv
// tb_hypot_req_arbiter: directed checks of hypot_req_arbiter against a behavioural engine
module tb_hypot_req_arbiter;
  localparam int NREQ = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*W-1:0] req_x = {8'd5, 8'd3, 8'd8, 8'd6};
  logic [NREQ*W-1:0] req_y = {8'd12, 8'd4, 8'd15, 8'd8};
  logic [NREQ-1:0] req_ready, rsp_valid;
  logic eng_start, eng_done, rsp_err, busy;
  logic [W-1:0] eng_x, eng_y, eng_result, rsp_data;
  logic [1:0] grant_id;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int bad_oh = 0;
  int rsp_cnt = 0;
  int eng_lat = 10;
  int eng_fixed = -1;
  int exp_d[4] = '{10, 17, 5, 13};
  hypot_req_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .eng_done(eng_done), .eng_result(eng_result), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .grant_id(grant_id)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!$onehot0(req_ready) || !$onehot0(rsp_valid)) bad_oh++;
    if (|rsp_valid) rsp_cnt++;
  end
  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction
  initial begin
    int ex, ey;
    eng_done = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clk);
      if (eng_start && eng_lat > 0) begin
        ex = int'(eng_x);
        ey = int'(eng_y);
        repeat (eng_lat) @(negedge clk);
        eng_result = eng_fixed >= 0 ? W'(eng_fixed) : W'(isqrt(ex * ex + ey * ey));
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic wait_for(input bit rsp);
    int n = 0;
    while (!(rsp ? |rsp_valid : eng_start) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check(rsp ? "wait_rsp" : "wait_start", 0, 1);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    int s, n;
    repeat (2) @(negedge clk);
    check("reset", {busy, req_ready, eng_start, rsp_valid, grant_id, rsp_data, rsp_err, eng_x, eng_y}, 0);
    rst = 1'b0;
    req_valid = 4'b0100;
    wait_for(0);
    s = cyc;
    check("t1_ready", req_ready, 4'b0100);
    check("t1_x", eng_x, 3);
    check("t1_y", eng_y, 4);
    check("t1_grant", grant_id, 2);
    @(negedge clk);
    req_valid = '0;
    check("t1_pulse", {eng_start, req_ready}, 0);
    wait_for(1);
    check("t1_lat", cyc - s, 11);
    check("t1_rsp", rsp_valid, 4'b0100);
    check("t1_data", rsp_data, 5);
    check("t1_err", rsp_err, 0);
    @(negedge clk);
    check("t1_idle", {busy, rsp_valid}, 0);
    check("t1_hold", rsp_data, 5);
    do_reset();
    eng_lat = 5;
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      wait_for(0);
      check("t2_grant", grant_id, k % 4);
      check("t2_ready", req_ready, 1 << (k % 4));
      wait_for(1);
      check("t2_rsp", rsp_valid, 1 << (k % 4));
      check("t2_data", rsp_data, exp_d[k % 4]);
      if (k == 5) req_valid = '0;
    end
    do_reset();
    req_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_for(0);
      check("t3_grant", grant_id, (k % 2) != 0 ? 3 : 0);
      wait_for(1);
      check("t3_data", rsp_data, (k % 2) != 0 ? 13 : 10);
      if (k == 3) req_valid = '0;
    end
    @(negedge clk);
    eng_lat = 0;
    req_valid = 4'b0010;
    wait_for(0);
    s = cyc;
    check("t4_grant", grant_id, 1);
    @(negedge clk);
    req_valid = '0;
    wait_for(1);
    check("t4_lat", cyc - s, 65);
    check("t4_rsp", rsp_valid, 4'b0010);
    check("t4_err", rsp_err, 1);
    check("t4_data", rsp_data, 0);
    eng_lat = 3;
    @(negedge clk);
    req_valid = 4'b0001;
    wait_for(0);
    check("t4_next_grant", grant_id, 0);
    @(negedge clk);
    req_valid = '0;
    wait_for(1);
    check("t4_next_data", rsp_data, 10);
    check("t4_next_err", rsp_err, 0);
    eng_lat = 64;
    eng_fixed = 9;
    @(negedge clk);
    req_valid = 4'b0100;
    wait_for(0);
    s = cyc;
    @(negedge clk);
    req_valid = '0;
    wait_for(1);
    check("t5_lat", cyc - s, 65);
    check("t5_err", rsp_err, 0);
    check("t5_data", rsp_data, 9);
    eng_fixed = -1;
    eng_lat = 10;
    @(negedge clk);
    req_valid = 4'b0010;
    wait_for(0);
    s = cyc;
    @(negedge clk);
    req_valid = '0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = rsp_cnt;
    check("t6_busy", {busy, rsp_valid}, 0);
    repeat (4) @(negedge clk);
    check("t6_norsp", rsp_cnt, n);
    check("t6_stale", busy, 0);
    req_valid = 4'b0011;
    wait_for(0);
    check("t6_grant", grant_id, 0);
    check("t6_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    wait_for(1);
    check("t6_data", rsp_data, 10);
    check("onehot", bad_oh, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hypot_req_arbiter.md
Name: hypot_req_arbiter

Overview:
- Round-robin scheduler that shares one multi-cycle hypotenuse engine, sqrt(x^2+y^2), between NREQ requesters.
- Captures a requester's operand pair and starts the engine.
- Waits for completion, with a watchdog timeout, and returns the result to the granted requester.
- Sits between the pin-level input logic and the shared magnitude datapath; only this block drives the engine.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand and result width.
- TIMEOUT, 64, maximum engine wait cycles before aborting with an error (>=2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high (clk/rst; no _n because polarity is high).
- req_valid  in  NREQ  request pending per requester.
- req_x  in  NREQ*W  requester i x operand at [i*W +: W].
- req_y  in  NREQ*W  requester i y operand at [i*W +: W].
- req_ready  out  NREQ  one-hot, one-cycle accept pulse.
- eng_start  out  1  one-cycle engine start pulse.
- eng_x  out  W  latched x to engine; stable from start until response.
- eng_y  out  W  latched y to engine; stable from start until response.
- eng_done  in  1  engine completion pulse.
- eng_result  in  W  engine result; valid when eng_done=1.
- rsp_valid  out  NREQ  one-hot, one-cycle response pulse.
- rsp_data  out  W  result; valid with rsp_valid.
- rsp_err  out  1  timeout flag; valid with rsp_valid.
- busy  out  1  high when state != IDLE.
- grant_id  out  clog2(NREQ)  index of current or last granted requester.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, all outputs 0, timer=0, last_grant=NREQ-1, so requester 0 wins first.
- Reset mid-operation abandons the transaction: no rsp_valid and no re-issue. A late eng_done after reset is ignored.
- All registered outputs; no combinational path from inputs to outputs.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, any req_valid high:
  - Pick the first valid index scanning last_grant+1, last_grant+2, ... modulo NREQ.
  - Latch its x/y into eng_x/eng_y, set grant_id, go to ISSUE.
  - No valid: stay.
- ISSUE (one cycle): eng_start=1, req_ready[grant_id]=1, timer cleared, go to WAIT.
  - Requester must hold req_valid and data until it samples req_ready high.
  - It drops req_valid or presents a new request the cycle after.
  - Operands are already latched, so data changes during ISSUE have no effect.
- WAIT: timer increments each cycle, starting at 0 on first WAIT cycle.
  - eng_done=1: capture eng_result, err=0, go to RESP.
  - Else if timer==TIMEOUT-1: data=0, err=1, go to RESP.
  - eng_done in the timeout cycle: done wins, err=0.
- RESP (one cycle): rsp_valid[grant_id]=1, rsp_data and rsp_err driven; last_grant<=grant_id; go to IDLE.
- rsp_data and rsp_err hold their values after RESP until the next RESP.
- Cycle timing:
  - Request seen in IDLE at cycle t: eng_start at t+1.
  - eng_done at cycle d: rsp_valid at d+1.
  - Timeout: rsp_valid at (eng_start cycle)+TIMEOUT+1.
  - Back-to-back overhead: 3 cycles plus engine latency.
- eng_done outside WAIT is ignored.
- x=y=0 is a legal request and is issued to the engine normally.
- req_valid with no grant persists; no starvation: each waiting requester is served within NREQ transactions.

Test Plan:
- Single request: after reset, requester 2 presents x=3, y=4; engine model returns 5 ten cycles after start.
  -> req_ready=4'b0100 one pulse; eng_start one pulse with eng_x=3, eng_y=4; rsp_valid=4'b0100 one cycle after eng_done; rsp_data=5; rsp_err=0; busy low after RESP.
- All four req_valid held high after reset, engine latency 5.
  -> grant order 0,1,2,3,0,1,...; exactly one req_ready and one rsp_valid per transaction; never two bits set.
- Requesters 0 and 3 continuously valid with x=6/y=8 and x=5/y=12.
  -> grants alternate 0,3,0,3; rsp_data alternates 10, 13.
- Engine never asserts done.
  -> rsp_valid exactly 65 cycles after eng_start; rsp_err=1; rsp_data=0; next request is served normally.
- eng_done asserted with result 9 in the timeout cycle (64 cycles after eng_start).
  -> rsp_valid next cycle; rsp_err=0; rsp_data=9.
- rst pulsed in WAIT, then stale eng_done 3 cycles later; requesters 1 and 0 valid.
  -> no rsp_valid; busy=0 after reset; stale done ignored; next grant goes to requester 0.
